instr_byte_loader: RTL and testbench
====================================

# instr_byte_loader

Parametrised byte-stream-to-word loader for the UART boot path. It receives a header byte holding the word count, then packs each following group of WORD_WIDTH/8 bytes into one word and writes it into the instruction memory through a single-cycle write port. It generalises the fixed 32-bit, MSB-first shift register: word width, memory depth and byte order are configurable, and it adds overflow detection, completion status and automatic re-arm.

## Interface
Parameters:
- WORD_WIDTH, default 32: assembled word width; must be a multiple of 8 and at least 8. BYTES = WORD_WIDTH/8.
- DEPTH, default 8: number of memory words. ADDR_W = max(1, $clog2(DEPTH)).
- MSB_FIRST, default 1: byte order.
  - 1: the first byte of a word lands in bits [WORD_WIDTH-1:WORD_WIDTH-8].
  - 0: the first byte lands in bits [7:0].

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- arst  in  1  reset; asynchronous and active-high.
- byte_valid  in  1  accept strobe; each cycle it is high accepts one byte.
- byte_in  in  8  byte presented with byte_valid.
- mem_we  out  1  write strobe, high for exactly one cycle per stored word.
- mem_addr  out  ADDR_W  word index for the current write.
- mem_wdata  out  WORD_WIDTH  assembled word.
- word_count  out  8  word count latched from the header byte.
- busy  out  1  high while state is LOAD.
- done  out  1  high in DONE; cleared when the next header byte is accepted.
- err_overflow  out  1  header exceeded DEPTH; cleared when the next header byte is accepted.

## Operation
- States: IDLE, LOAD, DONE. Reset puts the block in IDLE.
- IDLE or DONE, byte_valid=1: the byte is a header.
  - word_count <= byte_in; word index and byte index <= 0.
  - done <= 0; err_overflow <= (byte_in > DEPTH).
  - Header 0: go to DONE; done <= 1; no writes.
  - Header nonzero: go to LOAD.
- LOAD, byte_valid=1: shift byte_in into the assembly register in the order set by MSB_FIRST; byte index increments.
- LOAD, byte_valid=1 on the last byte of a word (byte index = BYTES-1):
  - mem_wdata <= the complete word, including this byte; mem_addr <= word index.
  - mem_we <= 1 only if word index < DEPTH. Words at index DEPTH or above are consumed but not written, so the sender stays framed.
  - Byte index <= 0; word index increments.
  - If word index = word_count-1: go to DONE and set done <= 1 on the same edge as the final write.
- byte_valid=0: no state change; mem_we <= 0.
- DONE is not sticky: the next accepted byte starts a new load (re-arm).

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, busy=0, done=0, err_overflow=0. The assembly register, byte index and word index are also cleared.
- Reset asserted mid-load aborts the load immediately (asynchronous). A partial word is discarded, and no write is issued.
- Latency: mem_we is registered and asserts in the cycle after the edge that samples the word's last byte. mem_addr and mem_wdata are valid in that same cycle.
- mem_we is never high for two consecutive cycles when BYTES > 1. When BYTES = 1, back-to-back bytes give back-to-back writes.
- busy rises the cycle after the header edge and falls on the same edge that sets done.
- Gaps of any length between bytes are allowed. There is no timeout; the block waits in LOAD indefinitely.
- Total bytes for header N: 1 + N*BYTES.

## Test plan
- Defaults, header 8'd3, then bytes 00 00 05 13, 00 10 05 93, 00 A0 06 13 with 10 idle cycles between bytes:
  - writes at addr 0, 1, 2 with data 32'h00000513, 32'h00100593, 32'h00A00613;
  - exactly 3 mem_we pulses; done=1 and err_overflow=0 at the end.
- MSB_FIRST=0, WORD_WIDTH=16, header 8'd1, bytes 34 12:
  - one write of 16'h1234 at addr 0.
- Defaults, header 8'd10, then 40 bytes:
  - err_overflow=1 from the header edge;
  - writes only at addr 0-7, no mem_we for words 8-9;
  - done=1 after byte 40.
- Header 8'd0:
  - done=1 on the edge after the header; busy never high; no mem_we.
- Header 8'd2, 6 bytes sent, arst pulsed:
  - all outputs return to 0 immediately; no write for the partial word 1.
  - A new header 8'd1 plus 00 00 00 6F then writes 32'h0000006F at addr 0.
- Back-to-back loads:
  - after done, header 8'd1 clears done on that edge and raises busy next cycle;
  - the new word is written at addr 0.

Source files
------------

// File: rtl/instr_byte_loader.sv
// instr_byte_loader: boot-path byte stream to instruction-word loader.
// A header byte gives the word count; each following group of bytes becomes one memory write.
module instr_byte_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic [7:0]            word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow
);

    localparam int          BYTES   = WORD_WIDTH / 8;
    localparam int          BI_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned DEPTH_U = DEPTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_WIDTH-1:0] r_asm;
    logic [BI_W-1:0]       r_byte_idx;
    logic [7:0]            r_word_idx;

    logic                  w_hdr;
    logic                  w_byte;
    logic                  w_word_end;
    logic                  w_last_word;
    logic [WORD_WIDTH-1:0] w_shifted;

    assign w_word_end  = (r_byte_idx == BI_W'(BYTES - 1));
    assign w_last_word = (r_word_idx == word_count - 8'd1);
    // New byte enters at the low end (MSB first) or at the high end (LSB first),
    // so after BYTES shifts the first byte sits in its final lane.
    assign w_shifted   = MSB_FIRST
                       ? ((r_asm << 8) | WORD_WIDTH'(byte_in))
                       : ((r_asm >> 8) | (WORD_WIDTH'(byte_in) << (WORD_WIDTH - 8)));
    assign busy        = (r_state == LOAD);

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle byte classification
    always_comb begin
        w_state_nxt = r_state;
        w_hdr       = 1'b0;
        w_byte      = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (byte_valid) begin
                    w_hdr       = 1'b1;
                    w_state_nxt = (byte_in == 8'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (byte_valid) begin
                    w_byte = 1'b1;
                    if (w_word_end && w_last_word) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: header capture, byte packing and the registered write port
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_asm        <= '0;
            r_byte_idx   <= '0;
            r_word_idx   <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            word_count   <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (w_hdr) begin
                word_count   <= byte_in;
                r_word_idx   <= '0;
                r_byte_idx   <= '0;
                r_asm        <= '0;
                done         <= (byte_in == 8'd0);
                err_overflow <= (32'(byte_in) > DEPTH_U);
            end else if (w_byte) begin
                r_asm <= w_shifted;
                if (w_word_end) begin
                    mem_wdata  <= w_shifted;
                    mem_addr   <= ADDR_W'(r_word_idx);
                    // Words past the memory are swallowed to keep the stream framed.
                    mem_we     <= (32'(r_word_idx) < DEPTH_U);
                    r_byte_idx <= '0;
                    r_word_idx <= r_word_idx + 8'd1;
                    if (w_last_word) begin
                        done <= 1'b1;
                    end
                end else begin
                    r_byte_idx <= r_byte_idx + BI_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_byte_loader.sv
// tb_instr_byte_loader: scoreboard bench for instr_byte_loader.
// Two instances: default 32-bit MSB-first, and 16-bit LSB-first.
module tb_instr_byte_loader;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr32_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr16_t;

    logic        clk = 1'b0;
    logic        arst;
    logic        bv;
    logic [7:0]  bi;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  word_count;
    logic        busy;
    logic        done;
    logic        err_overflow;

    logic        bv16;
    logic [7:0]  bi16;
    logic        mem_we16;
    logic [2:0]  mem_addr16;
    logic [15:0] mem_wdata16;
    logic [7:0]  word_count16;
    logic        busy16;
    logic        done16;
    logic        err16;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr32   = 0;
    int n_wr16   = 0;
    logic prev_we32 = 1'b0;

    wr32_t q32[$];
    wr16_t q16[$];

    always #5 clk = ~clk;

    instr_byte_loader u_dut (
        .clk          (clk),
        .arst         (arst),
        .byte_valid   (bv),
        .byte_in      (bi),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow)
    );

    instr_byte_loader #(
        .WORD_WIDTH (16),
        .DEPTH      (8),
        .MSB_FIRST  (1'b0)
    ) u_dut16 (
        .clk          (clk),
        .arst         (arst),
        .byte_valid   (bv16),
        .byte_in      (bi16),
        .mem_we       (mem_we16),
        .mem_addr     (mem_addr16),
        .mem_wdata    (mem_wdata16),
        .word_count   (word_count16),
        .busy         (busy16),
        .done         (done16),
        .err_overflow (err16)
    );

    // Scoreboard for the 32-bit instance
    always @(negedge clk) begin
        wr32_t e;
        if (mem_we === 1'b1) begin
            n_wr32++;
            n_checks++;
            if (prev_we32) begin
                n_errors++;
                $display("FAIL we_consecutive: mem_we high two cycles, addr=%0d", mem_addr);
            end
            n_checks++;
            if (q32.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write32: addr=%0d data=%h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                e = q32.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    n_errors++;
                    $display("FAIL write32: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
        prev_we32 = (mem_we === 1'b1);
    end

    // Scoreboard for the 16-bit LSB-first instance
    always @(negedge clk) begin
        wr16_t e;
        if (mem_we16 === 1'b1) begin
            n_wr16++;
            n_checks++;
            if (q16.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write16: addr=%0d data=%h, none expected",
                         mem_addr16, mem_wdata16);
            end else begin
                e = q16.pop_front();
                if (mem_addr16 !== e.addr || mem_wdata16 !== e.data) begin
                    n_errors++;
                    $display("FAIL write16: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr16, mem_wdata16, e.addr, e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send32(input logic [7:0] b, input int gap);
        bv = 1'b1;
        bi = b;
        @(posedge clk);
        #1;
        bv = 1'b0;
        idle(gap);
    endtask

    task automatic send16(input logic [7:0] b, input int gap);
        bv16 = 1'b1;
        bi16 = b;
        @(posedge clk);
        #1;
        bv16 = 1'b0;
        idle(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit last);
        send32(w[31:24], gap);
        send32(w[23:16], gap);
        send32(w[15:8], gap);
        send32(w[7:0], last ? 0 : gap);
    endtask

    task automatic push32(input int a, input logic [31:0] d);
        wr32_t e;
        e.addr = 3'(a);
        e.data = d;
        q32.push_back(e);
    endtask

    task automatic test_reset;
        arst = 1'b1;
        bv   = 1'b0;
        bi   = 8'h00;
        bv16 = 1'b0;
        bi16 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count, busy, done, err_overflow} !== '0) begin
            n_errors++;
            $display("FAIL reset32: we=%b addr=%0d data=%h cnt=%0d busy=%b done=%b err=%b, all 0 required",
                     mem_we, mem_addr, mem_wdata, word_count, busy, done, err_overflow);
        end
        n_checks++;
        if ({mem_we16, mem_addr16, mem_wdata16, word_count16, busy16, done16, err16} !== '0) begin
            n_errors++;
            $display("FAIL reset16: outputs not all 0 (data=%h cnt=%0d)", mem_wdata16, word_count16);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load3;
        int w0;
        w0 = n_wr32;
        push32(0, 32'h00000513);
        push32(1, 32'h00100593);
        push32(2, 32'h00A00613);
        send32(8'd3, 10);
        send_word(32'h00000513, 10, 0);
        send_word(32'h00100593, 10, 0);
        send_word(32'h00A00613, 10, 1);
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_errors++;
            $display("FAIL load3_latency: mem_we=%b after last byte, required 1", mem_we);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL load3_status: done=%b busy=%b err=%b, required 1 0 0",
                     done, busy, err_overflow);
        end
        @(posedge clk);
        #1;
        idle(3);
        n_checks++;
        if (n_wr32 - w0 != 3 || q32.size() != 0) begin
            n_errors++;
            $display("FAIL load3_count: writes=%0d pending=%0d, required 3 and 0",
                     n_wr32 - w0, q32.size());
        end
        n_checks++;
        if (word_count !== 8'd3) begin
            n_errors++;
            $display("FAIL load3_word_count: %0d, required 3", word_count);
        end
    endtask

    task automatic test_lsb16;
        wr16_t e;
        e.addr = 3'd0;
        e.data = 16'h1234;
        q16.push_back(e);
        send16(8'd1, 2);
        send16(8'h34, 2);
        send16(8'h12, 0);
        @(negedge clk);
        n_checks++;
        if (mem_we16 !== 1'b1 || done16 !== 1'b1) begin
            n_errors++;
            $display("FAIL lsb16_status: we=%b done=%b, required 1 1", mem_we16, done16);
        end
        @(posedge clk);
        #1;
        idle(3);
        n_checks++;
        if (n_wr16 != 1 || q16.size() != 0) begin
            n_errors++;
            $display("FAIL lsb16_count: writes=%0d pending=%0d, required 1 and 0",
                     n_wr16, q16.size());
        end
    endtask

    task automatic test_overflow;
        int w0;
        logic [31:0] w;
        w0 = n_wr32;
        send32(8'd10, 0);
        @(negedge clk);
        n_checks++;
        if (err_overflow !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_header: err=%b busy=%b done=%b, required 1 1 0",
                     err_overflow, busy, done);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            w = 32'h11223300 + 32'(k);
            if (k < 8) push32(k, w);
            send_word(w, 0, k == 9);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_done: done=%b busy=%b, required 1 0", done, busy);
        end
        @(posedge clk);
        #1;
        idle(3);
        n_checks++;
        if (n_wr32 - w0 != 8 || q32.size() != 0) begin
            n_errors++;
            $display("FAIL ovf_count: writes=%0d pending=%0d, required 8 and 0",
                     n_wr32 - w0, q32.size());
        end
        n_checks++;
        if (err_overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: err=%b, required 1", err_overflow);
        end
    endtask

    task automatic test_zero;
        int w0;
        w0 = n_wr32;
        send32(8'd0, 0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_header: done=%b busy=%b err=%b, required 1 0 0",
                     done, busy, err_overflow);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                n_errors++;
                $display("FAIL zero_busy: busy=%b at cycle %0d, required 0", busy, i);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (n_wr32 != w0) begin
            n_errors++;
            $display("FAIL zero_writes: %0d writes, required 0", n_wr32 - w0);
        end
    endtask

    task automatic test_reset_midload;
        int w0;
        w0 = n_wr32;
        push32(0, 32'hDEADBEEF);
        send32(8'd2, 1);
        send_word(32'hDEADBEEF, 1, 0);
        send32(8'hCA, 1);
        send32(8'hFE, 1);
        @(negedge clk);
        arst = 1'b1;
        #1;
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count, busy, done, err_overflow} !== '0) begin
            n_errors++;
            $display("FAIL midload_reset: we=%b addr=%0d data=%h cnt=%0d busy=%b done=%b, all 0 required",
                     mem_we, mem_addr, mem_wdata, word_count, busy, done);
        end
        #2;
        arst = 1'b0;
        @(posedge clk);
        #1;
        idle(3);
        n_checks++;
        if (n_wr32 - w0 != 1 || q32.size() != 0) begin
            n_errors++;
            $display("FAIL midload_writes: writes=%0d pending=%0d, required 1 and 0",
                     n_wr32 - w0, q32.size());
        end
        push32(0, 32'h0000006F);
        send32(8'd1, 0);
        send_word(32'h0000006F, 0, 1);
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL midload_reload: we=%b done=%b, required 1 1", mem_we, done);
        end
        @(posedge clk);
        #1;
        idle(2);
    endtask

    task automatic test_back_to_back;
        push32(0, 32'h12345678);
        send32(8'd1, 0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || word_count !== 8'd1) begin
            n_errors++;
            $display("FAIL b2b_rearm: done=%b busy=%b cnt=%0d, required 0 1 1",
                     done, busy, word_count);
        end
        @(posedge clk);
        #1;
        send_word(32'h12345678, 0, 1);
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 3'd0 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_write: we=%b addr=%0d done=%b, required 1 0 1",
                     mem_we, mem_addr, done);
        end
        @(posedge clk);
        #1;
        idle(3);
        n_checks++;
        if (q32.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_pending: %0d writes not seen, required 0", q32.size());
        end
    endtask

    initial begin
        test_reset;
        test_load3;
        test_lsb16;
        test_overflow;
        test_zero;
        test_reset_midload;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
